// File: rtl/fir_ctrl_if.sv
// Stream handshake bundle between fir_ctrl and the AXI-Stream side of fir_top.
interface fir_ctrl_if;
  logic in_ss_tvalid;
  logic in_ss_tlast;
  logic out_ss_tready;
  logic in_sm_tready;
  logic out_sm_tvalid;
  logic out_sm_tlast;

  modport master (
    output in_ss_tvalid, in_ss_tlast, in_sm_tready,
    input  out_ss_tready, out_sm_tvalid, out_sm_tlast
  );

  modport slave (
    input  in_ss_tvalid, in_ss_tlast, in_sm_tready,
    output out_ss_tready, out_sm_tvalid, out_sm_tlast
  );
endinterface

// File: rtl/fir_ctrl.sv
// Run sequencer for the FIR engine: clears the data window, schedules one MAC
// pass per input sample over circular data RAM and hands results to the output stream.
module fir_ctrl #(
  parameter int TAP_NUM_WIDTH  = 10,
  parameter int DATA_NUM_WIDTH = 10
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  fir_ctrl_if.slave                 axis,
  input  logic                      in_ap_start,
  input  logic                      in_done_clr,
  input  logic [TAP_NUM_WIDTH-1:0]  in_tap_num,
  input  logic [31:0]               in_data_len,
  output logic                      out_ap_done,
  output logic                      out_ap_idle,
  output logic                      out_data_EN,
  output logic                      out_data_WE,
  output logic [DATA_NUM_WIDTH-1:0] out_data_A,
  output logic                      out_din_zero,
  output logic                      out_tap_EN,
  output logic [TAP_NUM_WIDTH-1:0]  out_tap_A,
  output logic                      out_tap_own,
  output logic                      out_mac_clr,
  output logic                      out_mac_en
);

  localparam logic [TAP_NUM_WIDTH-1:0]  TAP_ONE  = TAP_NUM_WIDTH'(1);
  localparam logic [DATA_NUM_WIDTH-1:0] DATA_ONE = DATA_NUM_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_DRAIN, S_OUT, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  logic [TAP_NUM_WIDTH-1:0]  r_n, r_k;
  logic [31:0]               r_l, r_cnt;
  logic [DATA_NUM_WIDTH-1:0] r_wp, r_rp;
  logic                      r_tlast_seen, r_ap_done, r_mac_en, r_mac_clr;

  logic [DATA_NUM_WIDTH-1:0] w_n_d;
  logic w_idle, w_start, w_zero_cfg, w_k_last, w_wp_last, w_sm_last, w_done_set;
  logic w_ss_tready, w_sm_tvalid, w_sm_tlast;

  assign w_n_d      = DATA_NUM_WIDTH'(r_n);
  assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start    = w_idle && in_ap_start;
  assign w_zero_cfg = (in_tap_num == '0) || (in_data_len == '0);
  assign w_k_last   = (r_k == r_n - TAP_ONE);
  assign w_wp_last  = (r_wp == w_n_d - DATA_ONE);
  assign w_sm_last  = (r_cnt == r_l - 32'd1) || r_tlast_seen;
  assign w_done_set = (w_start && w_zero_cfg) ||
                      ((r_state == S_OUT) && axis.in_sm_tready && w_sm_last);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    out_data_EN  = 1'b0;
    out_data_WE  = 1'b0;
    out_data_A   = '0;
    out_din_zero = 1'b0;
    out_tap_EN   = 1'b0;
    out_tap_A    = '0;
    w_ss_tready  = 1'b0;
    w_sm_tvalid  = 1'b0;
    w_sm_tlast   = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (in_ap_start) w_state_next = w_zero_cfg ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        out_data_EN  = 1'b1;
        out_data_WE  = 1'b1;
        out_din_zero = 1'b1;
        out_data_A   = DATA_NUM_WIDTH'(r_k);
        if (w_k_last) w_state_next = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        // Write strobe stays up for the whole wait so it never depends on
        // ss_tvalid; slot wp holds the oldest sample and the handshake edge
        // leaves the real one in it.
        w_ss_tready = 1'b1;
        out_data_EN = 1'b1;
        out_data_WE = 1'b1;
        out_data_A  = r_wp;
        if (axis.in_ss_tvalid) w_state_next = S_MAC;
      end
      S_MAC: begin
        out_tap_EN  = 1'b1;
        out_tap_A   = r_k;
        out_data_EN = 1'b1;
        out_data_A  = r_rp;
        if (w_k_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_state_next = S_OUT;
      end
      S_OUT: begin
        w_sm_tvalid = 1'b1;
        w_sm_tlast  = w_sm_last;
        if (axis.in_sm_tready) w_state_next = w_sm_last ? S_DONE : S_WAIT_IN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_n          <= '0;
      r_k          <= '0;
      r_l          <= '0;
      r_cnt        <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_tlast_seen <= 1'b0;
      r_mac_en     <= 1'b0;
      r_mac_clr    <= 1'b0;
    end else begin
      // RAM reads land one cycle later, so the accumulate strobes trail MAC.
      r_mac_en  <= (r_state == S_MAC);
      r_mac_clr <= (r_state == S_MAC) && (r_k == '0);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (in_ap_start) begin
            r_n          <= in_tap_num;
            r_l          <= in_data_len;
            r_cnt        <= '0;
            r_wp         <= '0;
            r_k          <= '0;
            r_tlast_seen <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_k <= w_k_last ? '0 : r_k + TAP_ONE;
        end
        S_WAIT_IN: begin
          if (axis.in_ss_tvalid) begin
            r_tlast_seen <= axis.in_ss_tlast;
            r_rp         <= r_wp;
            r_k          <= '0;
          end
        end
        S_MAC: begin
          r_k  <= w_k_last ? '0 : r_k + TAP_ONE;
          r_rp <= (r_rp == '0) ? w_n_d - DATA_ONE : r_rp - DATA_ONE;
        end
        S_DRAIN: begin
          r_wp <= w_wp_last ? '0 : r_wp + DATA_ONE;
        end
        S_OUT: begin
          if (axis.in_sm_tready) r_cnt <= r_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // done_clr beats a coincident set; a start only clears a flag it is not setting.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ap_done <= 1'b0;
    end else if (in_done_clr) begin
      r_ap_done <= 1'b0;
    end else if (w_done_set) begin
      r_ap_done <= 1'b1;
    end else if (w_start) begin
      r_ap_done <= 1'b0;
    end
  end

  assign out_ap_done        = r_ap_done;
  assign out_ap_idle        = w_idle;
  assign out_tap_own        = !w_idle;
  assign out_mac_en         = r_mac_en;
  assign out_mac_clr        = r_mac_clr;
  assign axis.out_ss_tready = w_ss_tready;
  assign axis.out_sm_tvalid = w_sm_tvalid;
  assign axis.out_sm_tlast  = w_sm_tlast;

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: a behavioural tap/data RAM + MAC datapath around the DUT,
// outputs checked against a direct convolution of the stimulus.
`timescale 1ns/1ps
module tb_fir_ctrl;
  localparam int TW = 10;
  localparam int DW = 10;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          in_ap_start = 1'b0;
  logic          in_done_clr = 1'b0;
  logic [TW-1:0] in_tap_num = '0;
  logic [31:0]   in_data_len = '0;
  logic          out_ap_done, out_ap_idle, out_data_EN, out_data_WE, out_din_zero;
  logic          out_tap_EN, out_tap_own, out_mac_clr, out_mac_en;
  logic [DW-1:0] out_data_A;
  logic [TW-1:0] out_tap_A;
  int            ss_tdata = 0;

  fir_ctrl_if axis();

  fir_ctrl #(.TAP_NUM_WIDTH(TW), .DATA_NUM_WIDTH(DW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .axis        (axis),
    .in_ap_start (in_ap_start),
    .in_done_clr (in_done_clr),
    .in_tap_num  (in_tap_num),
    .in_data_len (in_data_len),
    .out_ap_done (out_ap_done),
    .out_ap_idle (out_ap_idle),
    .out_data_EN (out_data_EN),
    .out_data_WE (out_data_WE),
    .out_data_A  (out_data_A),
    .out_din_zero(out_din_zero),
    .out_tap_EN  (out_tap_EN),
    .out_tap_A   (out_tap_A),
    .out_tap_own (out_tap_own),
    .out_mac_clr (out_mac_clr),
    .out_mac_en  (out_mac_en)
  );

  always #5 aclk = ~aclk;

  int tap_ram  [0:1023];
  int data_ram [0:1023];
  int tap_q = 0, data_q = 0, acc = 0;

  always @(posedge aclk) begin
    if (out_data_EN) begin
      data_q <= data_ram[out_data_A];
      if (out_data_WE) data_ram[out_data_A] <= out_din_zero ? 0 : ss_tdata;
    end
    if (out_tap_EN) tap_q <= tap_ram[out_tap_A];
    if (out_mac_clr)     acc <= tap_q * data_q;
    else if (out_mac_en) acc <= acc + tap_q * data_q;
  end

  int h [0:1023];
  int x [0:1023];
  int imp_taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic int ref_y(input int i, input int n);
    int s = 0;
    for (int k = 0; k < n; k++)
      if (i - k >= 0) s += h[k] * x[i - k];
    return s;
  endfunction

  task automatic rand_vectors(input int n, input int l);
    for (int k = 0; k < n; k++) h[k] = int'($urandom_range(0, 200)) - 100;
    for (int i = 0; i < l; i++) x[i] = int'($urandom_range(0, 2000)) - 1000;
  endtask

  // Called on a negedge in IDLE/DONE with N > 0; returns on the first WAIT_IN negedge.
  task automatic start_and_clear(input int n, input int l);
    in_tap_num  = TW'(n);
    in_data_len = l;
    in_ap_start = 1'b1;
    @(negedge aclk);
    in_ap_start = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (j > 0) @(negedge aclk);
      check_val("clr_ctl", {out_data_EN, out_data_WE, out_din_zero, axis.out_ss_tready,
                            out_ap_idle, out_tap_own, out_tap_EN, out_ap_done}, 8'b11100100);
      check_val("clr_addr", out_data_A, j);
    end
    @(negedge aclk);
    check_val("tready_up", axis.out_ss_tready, 1);
  endtask

  task automatic do_run(input int n, input int l, input int tlast_idx,
                        input int bp_i, input int bp_len, input bit rnd);
    int   nout, wp, hold;
    logic exp_last;
    nout = (tlast_idx >= 0 && tlast_idx < l) ? tlast_idx + 1 : l;
    check_val("own_idle", out_tap_own, 0);
    for (int k = 0; k < n; k++) tap_ram[k] = h[k];
    start_and_clear(n, l);
    for (int i = 0; i < nout; i++) begin
      check_val("wait_in", {axis.out_ss_tready, axis.out_sm_tvalid}, 2'b10);
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge aclk);
      axis.in_ss_tvalid = 1'b1;
      axis.in_ss_tlast  = (i == tlast_idx);
      ss_tdata          = x[i];
      @(negedge aclk);
      axis.in_ss_tvalid = 1'b0;
      axis.in_ss_tlast  = 1'b0;
      wp = i % n;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge aclk);
        check_val("mac_ctl", {out_tap_EN, out_data_EN, out_data_WE, axis.out_ss_tready,
                              axis.out_sm_tvalid, out_ap_idle, out_tap_own}, 7'b1100001);
        check_val("tap_A", out_tap_A, k);
        check_val("data_A", out_data_A, (wp - k + n) % n);
        check_val("mac_strb", {out_mac_en, out_mac_clr}, k == 0 ? 2'b00 : (k == 1 ? 2'b11 : 2'b10));
        // A start and new config mid-run must be ignored.
        if (i == 1 && k == 0) begin
          in_ap_start = 1'b1;
          in_tap_num  = in_tap_num + TW'(3);
          in_data_len = 32'd2;
        end else begin
          in_ap_start = 1'b0;
        end
      end
      @(negedge aclk);
      in_ap_start = 1'b0;
      check_val("drain_ctl", {out_tap_EN, out_data_EN, axis.out_sm_tvalid,
                              axis.out_ss_tready, out_ap_idle}, 5'b00000);
      check_val("drain_strb", {out_mac_en, out_mac_clr}, n == 1 ? 2'b11 : 2'b10);
      @(negedge aclk);
      check_val("latency", axis.out_sm_tvalid, 1);
      exp_last = (i == nout - 1);
      hold = (i == bp_i) ? bp_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      check_val("y", acc, ref_y(i, n));
      check_val("tlast", axis.out_sm_tlast, exp_last);
      repeat (hold) begin
        @(negedge aclk);
        check_val("hold", {axis.out_sm_tvalid, axis.out_sm_tlast, axis.out_ss_tready},
                  {1'b1, exp_last, 1'b0});
      end
      axis.in_sm_tready = 1'b1;
      $display("N=%0d sample %0d: x=%0d y=%0d exp=%0d tlast=%0d hold=%0d",
               n, i, x[i], acc, ref_y(i, n), axis.out_sm_tlast, hold);
      @(negedge aclk);
      axis.in_sm_tready = 1'b0;
    end
    check_val("done", {out_ap_done, out_ap_idle, out_tap_own, axis.out_ss_tready}, 4'b1100);
  endtask

  task automatic clear_done();
    repeat (3) @(negedge aclk);
    check_val("done_sticky", out_ap_done, 1);
    in_done_clr = 1'b1;
    @(negedge aclk);
    in_done_clr = 1'b0;
    check_val("done_clr", out_ap_done, 0);
  endtask

  initial begin
    axis.in_ss_tvalid = 1'b0;
    axis.in_ss_tlast  = 1'b0;
    axis.in_sm_tready = 1'b0;
    repeat (3) @(negedge aclk);
    check_val("rst_state", {out_ap_idle, out_ap_done, out_tap_own, out_data_EN, out_data_WE,
                            out_din_zero, out_tap_EN, axis.out_ss_tready, axis.out_sm_tvalid,
                            axis.out_sm_tlast, out_mac_en, out_mac_clr}, 12'h800);
    aresetn = 1'b1;
    @(negedge aclk);
    check_val("post_rst", {out_ap_idle, out_ap_done, out_tap_own, axis.out_ss_tready}, 4'b1000);

    // Impulse response: outputs are the taps, then zeros.
    for (int k = 0; k < 11; k++) h[k] = imp_taps[k];
    for (int i = 0; i < 16; i++) x[i] = (i == 0) ? 1 : 0;
    do_run(11, 16, -1, -1, 0, 1'b0);
    clear_done();

    rand_vectors(4, 6);
    do_run(4, 6, -1, -1, 0, 1'b1);

    rand_vectors(5, 10);
    do_run(5, 10, -1, 3, 7, 1'b0);
    clear_done();

    // Long triangular run.
    rand_vectors(7, 0);
    for (int i = 0; i < 600; i++) x[i] = (i % 40 < 20) ? i % 40 : 40 - i % 40;
    do_run(7, 600, -1, -1, 0, 1'b1);

    rand_vectors(3, 20);
    do_run(3, 20, 4, -1, 0, 1'b1);

    rand_vectors(1, 8);
    do_run(1, 8, -1, 2, 3, 1'b1);
    clear_done();

    // Degenerate configs finish immediately.
    for (int c = 0; c < 2; c++) begin
      in_tap_num  = (c == 0) ? TW'(0) : TW'(4);
      in_data_len = (c == 0) ? 32'd5 : 32'd0;
      in_ap_start = 1'b1;
      @(negedge aclk);
      in_ap_start = 1'b0;
      check_val("zero_cfg", {out_ap_done, out_ap_idle, axis.out_ss_tready, out_tap_own}, 4'b1100);
      repeat (3) begin
        @(negedge aclk);
        check_val("zero_noready", {axis.out_ss_tready, out_data_EN}, 2'b00);
      end
      clear_done();
    end

    // Asynchronous reset in the middle of a MAC pass.
    rand_vectors(8, 4);
    for (int k = 0; k < 8; k++) tap_ram[k] = h[k];
    start_and_clear(8, 4);
    axis.in_ss_tvalid = 1'b1;
    ss_tdata = x[0];
    @(negedge aclk);
    axis.in_ss_tvalid = 1'b0;
    @(negedge aclk);
    check_val("pre_rst_mac", out_tap_EN, 1);
    #2 aresetn = 1'b0;
    #1;
    check_val("async_rst", {out_ap_idle, out_ap_done, out_tap_own, out_data_EN, out_data_WE,
                            out_din_zero, out_tap_EN, axis.out_ss_tready, axis.out_sm_tvalid,
                            axis.out_sm_tlast, out_mac_en, out_mac_clr}, 12'h800);
    check_val("async_rst_addr", {out_data_A, out_tap_A}, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (20) @(negedge aclk);
    check_val("rst_no_done", {out_ap_done, out_ap_idle, axis.out_sm_tvalid}, 3'b010);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
